// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial sequencer for an external 8-bit combinational adder: performs an
// 8*NBYTES-bit add one byte per clock, LSB first, chaining carry between bytes.
module byte_serial_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            is_run;
  logic            is_last;

  assign is_run  = (state_q == StRun);
  assign is_last = (idx_q == LastIdx);

  // Explicit byte mux keeps idx width independent of the operand width.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    add_a   = is_run ? a_byte  : 8'h00;
    add_b   = is_run ? b_byte  : 8'h00;
    add_cin = is_run ? carry_q : 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      StRun: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[8*i +: 8] = add_s;
          end
        end
        carry_d = add_cout;
        if (is_last) begin
          cout_d  = add_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StDone);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
